// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: register-file write-port arbiter between WB pipe and mul/div unit, with pending scoreboard and starvation stall
module reg_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PipeWrite_i,
  input  logic [4:0]  PipeAddr_i,
  input  logic [31:0] PipeData_i,
  input  logic        MdReq_i,
  input  logic [4:0]  MdAddr_i,
  input  logic [31:0] MdData_i,
  output logic        MdAck_o,
  input  logic        Issue_i,
  input  logic [4:0]  IssueAddr_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic        IDWrite_i,
  input  logic [4:0]  IDAddr_i,
  output logic        Stall_o,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o
);
  typedef enum logic [1:0] {IDLE, WAIT, STARVE} state_t;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx, cnt_inc;
  logic [31:0] pending, pending_nx;
  logic pipe_v, md_v, md_win, hazard, release_md;
  assign pipe_v = PipeWrite_i && PipeAddr_i != 5'd0;
  assign md_v = MdReq_i && MdAddr_i != 5'd0;
  assign MdAck_o = MdReq_i && !pipe_v;
  assign md_win = MdAck_o && md_v;
  assign hazard = pending[RSaddr_i] | pending[RTaddr_i] | (IDWrite_i & pending[IDAddr_i]);
  assign Stall_o = hazard | (state == STARVE);
  assign cnt_inc = (cnt == 3'd7) ? cnt : cnt + 3'd1;
  // a grant or a withdrawn request both end the wait
  assign release_md = !MdReq_i || MdAck_o;
  always_comb begin
    state_nx = release_md ? IDLE :
               (state == IDLE) ? WAIT :
               (state == STARVE || cnt_inc >= LIMIT) ? STARVE : WAIT;
    cnt_nx = release_md ? 3'd0 : (state == IDLE) ? 3'd1 : cnt_inc;
  end
  // set after clear so a same-edge reissue keeps the register pending
  always_comb begin
    pending_nx = pending;
    if (md_win) pending_nx[MdAddr_i] = 1'b0;
    if (Issue_i && !Stall_o && IssueAddr_i != 5'd0) pending_nx[IssueAddr_i] = 1'b1;
    pending_nx[0] = 1'b0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= 3'd0;
      pending <= 32'd0;
      RegWrite_o <= 1'b0;
      RDaddr_o <= 5'd0;
      RDdata_o <= 32'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pending <= pending_nx;
      RegWrite_o <= pipe_v || md_win;
      if (pipe_v) begin
        RDaddr_o <= PipeAddr_i;
        RDdata_o <= PipeData_i;
      end else if (md_win) begin
        RDaddr_o <= MdAddr_i;
        RDdata_o <= MdData_i;
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed scenarios plus random traffic against a behavioural write-port/scoreboard model
module tb_reg_wb_arbiter;
  localparam int LIMIT = 3;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic PipeWrite_i = 1'b0, MdReq_i = 1'b0, Issue_i = 1'b0, IDWrite_i = 1'b0;
  logic [4:0] PipeAddr_i = '0, MdAddr_i = '0, IssueAddr_i = '0, RSaddr_i = '0, RTaddr_i = '0, IDAddr_i = '0;
  logic [31:0] PipeData_i = '0, MdData_i = '0;
  logic MdAck_o, Stall_o, RegWrite_o;
  logic [4:0] RDaddr_o;
  logic [31:0] RDdata_o;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_pend = '0;
  int m_denied = 0;
  logic m_we = 1'b0, m_ack = 1'b0;
  logic [4:0] m_addr = '0;
  logic [31:0] m_data = '0;

  reg_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .PipeWrite_i(PipeWrite_i), .PipeAddr_i(PipeAddr_i), .PipeData_i(PipeData_i),
    .MdReq_i(MdReq_i), .MdAddr_i(MdAddr_i), .MdData_i(MdData_i), .MdAck_o(MdAck_o),
    .Issue_i(Issue_i), .IssueAddr_i(IssueAddr_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .IDWrite_i(IDWrite_i), .IDAddr_i(IDAddr_i),
    .Stall_o(Stall_o), .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mr, input logic [4:0] ma, input logic [31:0] md,
                       input logic is, input logic [4:0] ia,
                       input logic [4:0] rs, input logic [4:0] rt, input logic idw, input logic [4:0] ida);
    PipeWrite_i = pw; PipeAddr_i = pa; PipeData_i = pd;
    MdReq_i = mr; MdAddr_i = ma; MdData_i = md;
    Issue_i = is; IssueAddr_i = ia;
    RSaddr_i = rs; RTaddr_i = rt; IDWrite_i = idw; IDAddr_i = ida;
  endtask

  // one cycle: check combinational outputs, predict the edge, check registered outputs after it
  task automatic step();
    logic pv, ack, st, we;
    logic [4:0] a;
    logic [31:0] d, p;
    #1;
    pv = PipeWrite_i && PipeAddr_i != 5'd0;
    ack = MdReq_i && !pv;
    st = m_pend[RSaddr_i] || m_pend[RTaddr_i] || (IDWrite_i && m_pend[IDAddr_i]) || m_denied >= LIMIT;
    chk("ack", 32'(MdAck_o), 32'(ack));
    chk("stall", 32'(Stall_o), 32'(st));
    we = pv || (ack && MdAddr_i != 5'd0);
    a = pv ? PipeAddr_i : we ? MdAddr_i : m_addr;
    d = pv ? PipeData_i : we ? MdData_i : m_data;
    p = m_pend;
    if (ack && MdAddr_i != 5'd0) p[MdAddr_i] = 1'b0;
    if (Issue_i && !st && IssueAddr_i != 5'd0) p[IssueAddr_i] = 1'b1;
    m_denied = (MdReq_i && !ack) ? m_denied + 1 : 0;
    m_ack = ack;
    @(posedge clk_i);
    #1;
    m_we = we; m_addr = a; m_data = d; m_pend = p;
    chk("we", 32'(RegWrite_o), 32'(m_we));
    chk("addr", 32'(RDaddr_o), 32'(m_addr));
    chk("data", RDdata_o, m_data);
  endtask

  task automatic async_reset();
    #2 rst_i = 1'b1;
    #1;
    m_pend = '0; m_denied = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    chk("rst_stall", 32'(Stall_o), 32'd0);
    chk("rst_we", 32'(RegWrite_o), 32'd0);
    chk("rst_addr", 32'(RDaddr_o), 32'd0);
    chk("rst_data", RDdata_o, 32'd0);
    #3 rst_i = 1'b0;
  endtask

  initial begin
    #3;
    chk("por_we", 32'(RegWrite_o), 32'd0);
    chk("por_stall", 32'(Stall_o), 32'd0);
    chk("por_data", RDdata_o, 32'd0);
    #4 rst_i = 1'b0;
    // pipe-only write
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("pipe_only_data", RDdata_o, 32'hDEADBEEF);
    // collision: pipe first, md on the next idle cycle
    drive(1, 3, 32'h11, 1, 7, 32'h22, 0, 0, 0, 0, 0, 0); step();
    chk("coll_addr", 32'(RDaddr_o), 32'd3);
    drive(0, 0, 0, 1, 7, 32'h22, 0, 0, 0, 0, 0, 0); step();
    chk("coll_md_data", RDdata_o, 32'h22);
    // starvation: pipe writes every cycle while md waits
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'(i + 1), 32'(i), 1, 6, 32'h66, 0, 0, 0, 0, 0, 0); step();
    end
    chk("starve_stall", 32'(Stall_o), 32'd1);
    drive(0, 0, 0, 1, 6, 32'h66, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("starve_released", 32'(Stall_o), 32'd0);
    // scoreboard on r9, including same-edge issue and ack
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0); step();
    drive(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0); step();
    chk("reissue_pending", 32'(Stall_o), 32'd1);
    drive(0, 0, 0, 1, 9, 32'h9A, 0, 0, 9, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 9); step();
    chk("r9_cleared", 32'(Stall_o), 32'd0);
    // r0 writes are not requests; issue to r0 never creates a hazard
    drive(1, 0, 32'hBAD, 1, 4, 32'h44, 1, 0, 0, 0, 0, 0); step();
    chk("r0_md_addr", 32'(RDaddr_o), 32'd4);
    drive(0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0, 1, 0); step();
    chk("md_r0_nowrite", 32'(RegWrite_o), 32'd0);
    // async reset in the middle of STARVE with a pending register
    drive(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 32'(i), 1, 8, 32'h88, 0, 0, 12, 0, 0, 0); step();
    end
    chk("pre_rst_stall", 32'(Stall_o), 32'd1);
    async_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 1, 12); step();
    // random traffic; md unit holds its request until acked, with rare illegal drops
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      logic new_md;
      new_md = !MdReq_i || m_ack;
      PipeWrite_i = ($urandom_range(0, 2) != 0);
      PipeAddr_i = 5'($urandom_range(0, 7));
      PipeData_i = $urandom;
      if (new_md) begin
        MdReq_i = $urandom_range(0, 1) == 1;
        MdAddr_i = 5'($urandom_range(0, 7));
        MdData_i = $urandom;
      end else if ($urandom_range(0, 31) == 0) MdReq_i = 1'b0;
      Issue_i = $urandom_range(0, 3) == 0;
      IssueAddr_i = 5'($urandom_range(0, 7));
      RSaddr_i = 5'($urandom_range(0, 7));
      RTaddr_i = 5'($urandom_range(0, 7));
      IDWrite_i = $urandom_range(0, 1) == 1;
      IDAddr_i = 5'($urandom_range(0, 7));
      step();
      if (c == 300) async_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
